// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 UART receiver.
// Two-flop input synchronizer, start-bit detection, 3-sample majority vote at
// each bit centre, LSB-first data recovery, one-cycle received / frame_err
// strobes. data_received holds the last well-framed byte.
module uart_rx #(
    parameter int OVERSAMPLE = 16,  // clk ticks per bit, even and >= 4
    parameter int DATA_BITS  = 8    // data bits per frame, LSB first
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 received,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Counter values seen *before* the sampling edge. The tick counter reads
    // 0 after the start-detect edge D, so the edge at D+k sees k-1 (mod
    // OVERSAMPLE); the three samples at D+mid-1, D+mid, D+mid+1 therefore
    // land on counter values mid-2, mid-1, mid.
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [1:0]           r_state;
    logic [TICK_W-1:0]    r_tick;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;

    logic                 w_rx_s;
    logic                 w_at_vote;
    logic                 w_vote;

    assign w_rx_s    = r_sync2;
    assign w_at_vote = (r_tick == TICK_VOTE);
    assign busy      = (r_state != IDLE);

    // Bring the asynchronous line into the clk domain; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with <= so every flop samples
        // pre-edge values; blocking here would collapse the two stages.
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bit_in;
            r_sync2 <= r_sync1;
        end
    end

    // 2-of-3 majority of the two earlier centre samples and the current one.
    always_comb begin
        // NOTE: give every always_comb output a value on every path (a
        // default first) so no latch is inferred.
        w_vote = 1'b0;
        w_vote = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    end

    // Frame FSM: tick/bit counting, centre sampling, shifting and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_tick        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_s0          <= 1'b1;
            r_s1          <= 1'b1;
            data_received <= '0;
            received      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            received  <= 1'b0;
            frame_err <= 1'b0;

            if (r_state != IDLE) begin
                r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
            end
            if (r_tick == TICK_S0) begin
                r_s0 <= w_rx_s;
            end
            if (r_tick == TICK_S1) begin
                r_s1 <= w_rx_s;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_tick  <= '0;
                    end
                end
                START: begin
                    if (w_at_vote) begin
                        if (!w_vote) begin
                            r_state <= DATA;
                            r_bit   <= '0;
                        end else begin
                            // Start bit did not hold to its centre: a glitch.
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_at_vote) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BIT_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_at_vote) begin
                        if (w_vote) begin
                            data_received <= r_shift;
                            received      <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        // Leaving at stop centre lets an early next start in.
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx (16x oversample, 8N1).
// bit_in is driven 1 time unit after each rising edge, one value per tick.
// A line change after edge E0 is first seen by the FSM at E0+3 (= D), so a
// strobe set at D+153 is observed on the falling edge after E0+156.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic [7:0] data_received;
    logic       received;
    logic       frame_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .data_received(data_received),
        .received     (received),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Free-running cycle count and strobe monitor.
    int         cyc = 0;
    int         rcv_cnt = 0;
    int         ferr_cnt = 0;
    int         last_strobe_cyc = 0;
    int         fall_cyc = 0;
    int         width_err = 0;
    int         overlap_err = 0;
    logic       prev_rcv = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       busy_hi = 1'b0;
    logic [7:0] rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (received) begin
            rcv_cnt++;
            last_strobe_cyc = cyc;
            rq.push_back(data_received);
            if (prev_rcv) width_err++;
        end
        if (frame_err) begin
            ferr_cnt++;
            last_strobe_cyc = cyc;
            if (prev_ferr) width_err++;
        end
        if (received && frame_err) overlap_err++;
        if (busy) busy_hi = 1'b1;
        prev_rcv  = received;
        prev_ferr = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] data, input logic stop_val, input int n);
        if (n == 0) return 1'b0;
        if (n == 9) return stop_val;
        return data[n-1];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 bit_in = 1'b1;
        end
    endtask

    // One frame: 16 ticks per bit, optional 1-tick inverted spike at the centre
    // tick of data bit spike_bit, stop bit length stop_ticks.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int spike_bit, input int stop_ticks);
        logic b;
        int   len;
        for (int n = 0; n < 10; n++) begin
            b   = frame_bit(data, stop_val, n);
            len = (n == 9) ? stop_ticks : 16;
            for (int t = 0; t < len; t++) begin
                @(posedge clk);
                #1;
                bit_in = (spike_bit >= 0 && n == spike_bit + 1 && t == 8) ? ~b : b;
                if (n == 0 && t == 0) fall_cyc = cyc;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        int         spike_bit;
        int         exp_rcv;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    task automatic apply(input vec_t v, input string tag);
        int r0, f0;
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        send_frame(v.data, v.stop_val, v.spike_bit, 16);
        idle(30);
        check({tag, "_received_count"}, rcv_cnt - r0, v.exp_rcv);
        check({tag, "_frame_err_count"}, ferr_cnt - f0, v.exp_ferr);
        check({tag, "_data"}, data_received, v.exp_data);
        check({tag, "_latency"}, last_strobe_cyc - fall_cyc, 156);
    endtask

    vec_t vecs[5];

    initial begin
        int r0, f0;

        vecs[0] = '{8'hA5, 1'b1, -1, 1, 0, 8'hA5};  // clean frame
        vecs[1] = '{8'h55, 1'b1, -1, 1, 0, 8'h55};  // clean frame
        vecs[2] = '{8'h81, 1'b0, -1, 0, 1, 8'h55};  // stop low: keep 0x55
        vecs[3] = '{8'h00, 1'b1,  3, 1, 0, 8'h00};  // spike on bit 3 centre
        vecs[4] = '{8'hC3, 1'b1, -1, 1, 0, 8'hC3};  // clean frame

        // Reset state.
        rst    = 1'b1;
        bit_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_received, 8'h00);
        check("rst_received", received, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);
        check("idle_busy", busy, 1'b0);
        check("idle_strobes", rcv_cnt + ferr_cnt, 0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Start glitch: 4 low ticks then high; FSM back in IDLE by D+10.
        r0      = rcv_cnt;
        f0      = ferr_cnt;
        busy_hi = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1 bit_in = (k < 4) ? 1'b0 : 1'b1;
        end
        check("glitch_busy_seen", busy_hi, 1'b1);
        check("glitch_busy_low_by_d10", busy, 1'b0);
        idle(20);
        check("glitch_no_strobe", (rcv_cnt - r0) + (ferr_cnt - f0), 0);
        apply('{8'h3C, 1'b1, -1, 1, 0, 8'h3C}, "after_glitch");

        // Reset at D+70 (edge E0+73) while receiving 0xC3.
        check("pre_rst_data", data_received, 8'h3C);
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        for (int k = 0; k < 74; k++) begin
            @(posedge clk);
            #1 bit_in = frame_bit(8'hC3, 1'b1, k / 16);
        end
        rst    = 1'b1;
        bit_in = 1'b1;
        #1;
        check("midrst_data", data_received, 8'h00);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_strobes_low", {received, frame_err}, 2'b00);
        rst = 1'b0;
        idle(200);
        check("midrst_no_strobe", (rcv_cnt - r0) + (ferr_cnt - f0), 0);
        check("midrst_data_after", data_received, 8'h00);
        apply('{8'h5A, 1'b1, -1, 1, 0, 8'h5A}, "after_rst");

        // Back-to-back 0xFF then 0x00, second start 2 ticks early.
        rq.delete();
        f0 = ferr_cnt;
        send_frame(8'hFF, 1'b1, -1, 14);
        send_frame(8'h00, 1'b1, -1, 16);
        idle(30);
        check("b2b_count", rq.size(), 2);
        check("b2b_first", (rq.size() > 0) ? rq[0] : 8'hXX, 8'hFF);
        check("b2b_second", (rq.size() > 1) ? rq[1] : 8'hXX, 8'h00);
        check("b2b_frame_err", ferr_cnt - f0, 0);

        // Strobe shape over the whole run.
        check("strobe_width", width_err, 0);
        check("strobe_overlap", overlap_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
